// File: rtl/dsp_mem_write_router.sv
// Routes host writes from an ingress FIFO to an array of dsp_unit write ports.
// Supports unit decode, broadcast, per-unit backpressure and dropped-write accounting.
module dsp_mem_write_router #(
  parameter int DATA_WIDTH     = 32,
  parameter int N_DSP_UNIT     = 4,
  parameter int BUF_ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH     = 4,
  parameter int BCAST_EN       = 1,
  localparam int UNIT_W        = (N_DSP_UNIT > 1) ? $clog2(N_DSP_UNIT) : 1,
  localparam int LOC_W         = BUF_ADDR_WIDTH + 1,
  localparam int AW            = LOC_W + UNIT_W + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [AW-1:0]         in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [LOC_W-1:0]      out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [N_DSP_UNIT-1:0] out_en,
  input  logic [N_DSP_UNIT-1:0] out_ready,
  input  logic                  err_clr,
  output logic                  err_flag,
  output logic [7:0]            err_cnt,
  output logic [15:0]           wr_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [N_DSP_UNIT-1:0] MASK_ONE   = N_DSP_UNIT'(1);
  localparam logic [UNIT_W:0]       UNIT_LIMIT = (UNIT_W + 1)'(N_DSP_UNIT);

  logic [AW-1:0]         fifoAddr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifoData [FIFO_DEPTH];
  logic [PTR_W-1:0]      wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  accepting_q;

  logic                  outValid_q;
  logic [N_DSP_UNIT-1:0] outMask_q;
  logic [LOC_W-1:0]      outAddr_q;
  logic [DATA_WIDTH-1:0] outData_q;

  logic                  errFlag_q, errFlag_d;
  logic [7:0]            errCnt_q, errCnt_d;
  logic [15:0]           wrCnt_q, wrCnt_d;

  logic                  fifoEmpty, fifoFull, push, pop, go;
  logic [AW-1:0]         headAddr;
  logic                  headBcast, unitOk, headLegal;
  logic [UNIT_W-1:0]     headUnit;
  logic [LOC_W-1:0]      headLoc;
  logic [N_DSP_UNIT-1:0] headMask;
  logic                  loadOut, illegalPop;

  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == CNT_W'(FIFO_DEPTH));
  // in_ready stays low until the first edge after reset is released
  assign in_ready  = accepting_q & ~fifoFull;
  assign push      = in_valid & in_ready;

  assign go     = outValid_q & ((out_ready & outMask_q) == outMask_q);
  assign out_en = outMask_q & {N_DSP_UNIT{go}};
  assign pop    = ~fifoEmpty & (~outValid_q | go);

  assign headAddr  = fifoAddr[rdPtr_q];
  assign headBcast = headAddr[AW-1];
  assign headUnit  = headAddr[AW-2:LOC_W];
  assign headLoc   = headAddr[LOC_W-1:0];

  generate
    if (N_DSP_UNIT == (1 << UNIT_W)) begin : g_unit_full
      assign unitOk = 1'b1;
    end else begin : g_unit_partial
      assign unitOk = ({1'b0, headUnit} < UNIT_LIMIT);
    end
  endgenerate

  always_comb begin
    headMask  = '0;
    headLegal = 1'b0;
    if (headBcast) begin
      if (BCAST_EN != 0) begin
        headMask  = '1;
        headLegal = 1'b1;
      end
    end else if (unitOk) begin
      headMask  = MASK_ONE << headUnit;
      headLegal = 1'b1;
    end
  end

  assign loadOut    = pop & headLegal;
  assign illegalPop = pop & ~headLegal;

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      accepting_q <= 1'b0;
    end else begin
      accepting_q <= 1'b1;
      count_q     <= count_d;
      if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifoAddr[wrPtr_q] <= in_addr;
      fifoData[wrPtr_q] <= in_data;
    end
  end

  // Address and data are held after retirement; only a new legal entry replaces them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outValid_q <= 1'b0;
      outMask_q  <= '0;
      outAddr_q  <= '0;
      outData_q  <= '0;
    end else if (loadOut) begin
      outValid_q <= 1'b1;
      outMask_q  <= headMask;
      outAddr_q  <= headLoc;
      outData_q  <= fifoData[rdPtr_q];
    end else if (go) begin
      outValid_q <= 1'b0;
    end
  end

  always_comb begin
    errFlag_d = errFlag_q;
    errCnt_d  = errCnt_q;
    if (err_clr) begin
      errFlag_d = 1'b0;
      errCnt_d  = '0;
    end else if (illegalPop) begin
      errFlag_d = 1'b1;
      if (errCnt_q != 8'hFF) errCnt_d = errCnt_q + 8'd1;
    end
  end

  always_comb begin
    wrCnt_d = wrCnt_q;
    if (go && wrCnt_q != 16'hFFFF) wrCnt_d = wrCnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      errFlag_q <= 1'b0;
      errCnt_q  <= '0;
      wrCnt_q   <= '0;
    end else begin
      errFlag_q <= errFlag_d;
      errCnt_q  <= errCnt_d;
      wrCnt_q   <= wrCnt_d;
    end
  end

  assign out_addr = outAddr_q;
  assign out_data = outData_q;
  assign err_flag = errFlag_q;
  assign err_cnt  = errCnt_q;
  assign wr_cnt   = wrCnt_q;

endmodule
